systolic_result_drain: RTL

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_result_drain.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/systolic_result_drain.sv
// ----------------------------------------------------------------------------
// systolic_result_drain: double-banked capture of N x N PE results, drained
// as row-major M x M write beats.                                  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module systolic_result_drain #(
  parameter int D_W_ACC = 16,
  parameter int N       = 4,
  parameter int M       = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [D_W_ACC*N*N-1:0]            D,
  input  logic [N*N-1:0]                    valid_D,
  output logic                              wr_valid,
  input  logic                              wr_ready,
  output logic [$clog2(M*M)-1:0]            wr_addr,
  output logic [D_W_ACC-1:0]                wr_data,
  output logic [$clog2(M*M/(N*N)):0]        tile_cnt,
  output logic                              done,
  output logic                              overflow
);

  localparam int c_nn    = N * N;
  localparam int c_tiles = (M * M) / c_nn;
  localparam int c_tpr   = M / N;
  localparam int c_aw    = $clog2(M * M);
  localparam int c_bw    = $clog2(c_nn);
  localparam int c_tw    = $clog2(c_tiles) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [D_W_ACC-1:0] mem_q [2][c_nn];
  logic [c_nn-1:0]    mask_q [2];
  logic [c_nn-1:0]    mask_d [2];
  logic [1:0]         full_q, full_d;
  logic               cap_q, cap_d;
  logic               drn_q, drn_d;
  logic [c_bw-1:0]    beat_q, beat_d;
  logic [c_tw-1:0]    tile_q, tile_d;
  logic               ovf_q, ovf_d;

  logic [1:0]         w_full_cap;
  logic [c_nn-1:0]    w_wr_en;
  logic [c_nn-1:0]    w_mask_new;
  logic [c_aw-1:0]    w_addr;

  // Capture side: a full capture bank means both banks await drain.
  always_comb begin
    mask_d     = mask_q;
    w_full_cap = full_q;
    cap_d      = cap_q;
    ovf_d      = ovf_q;
    w_wr_en    = '0;
    w_mask_new = mask_q[cap_q];
    if (state_q == DONE || full_q[cap_q]) begin
      if (|valid_D) ovf_d = 1'b1;
    end else begin
      w_wr_en    = valid_D & ~mask_q[cap_q];
      w_mask_new = mask_q[cap_q] | w_wr_en;
      if (|(valid_D & mask_q[cap_q])) ovf_d = 1'b1;
      if (&w_mask_new) begin
        mask_d[cap_q]     = '0;
        w_full_cap[cap_q] = 1'b1;
        cap_d             = ~cap_q;
      end else begin
        mask_d[cap_q] = w_mask_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < c_nn; k++) begin
      if (w_wr_en[k]) mem_q[cap_q][k] <= D[k*D_W_ACC +: D_W_ACC];
    end
  end

  // Drain FSM sees this cycle's completion so the first beat has no bubble.
  always_comb begin
    state_d = state_q;
    full_d  = w_full_cap;
    drn_d   = drn_q;
    beat_d  = beat_q;
    tile_d  = tile_q;
    case (state_q)
      IDLE: begin
        if (w_full_cap[drn_q]) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_ready) begin
          if (beat_q == c_bw'(c_nn - 1)) begin
            beat_d        = '0;
            full_d[drn_q] = 1'b0;
            drn_d         = ~drn_q;
            tile_d        = tile_q + 1'b1;
            if (tile_q == c_tw'(c_tiles - 1)) state_d = DONE;
            else if (w_full_cap[~drn_q])      state_d = DRAIN;
            else                              state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q[0] <= '0;
      mask_q[1] <= '0;
      full_q    <= '0;
      cap_q     <= 1'b0;
      drn_q     <= 1'b0;
      beat_q    <= '0;
      tile_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      full_q  <= full_d;
      cap_q   <= cap_d;
      drn_q   <= drn_d;
      beat_q  <= beat_d;
      tile_q  <= tile_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    w_addr = c_aw'(((int'(tile_q) / c_tpr) * N + int'(beat_q) / N) * M
                   + (int'(tile_q) % c_tpr) * N + int'(beat_q) % N);
  end

  assign wr_valid = (state_q == DRAIN);
  assign wr_addr  = wr_valid ? w_addr : '0;
  assign wr_data  = wr_valid ? mem_q[drn_q][beat_q] : '0;
  assign tile_cnt = tile_q;
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

endmodule

`default_nettype wire
